// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter.
package vga_fb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // 640x480 @ 60 Hz horizontal timing (pixels)
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = 800;

    // 640x480 @ 60 Hz vertical timing (lines)
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = 525;

    // Framebuffer geometry defaults
    localparam int unsigned FB_ADDR_W     = 15;
    localparam int unsigned FB_DATA_W     = 8;
    localparam int unsigned FB_LINE_WORDS = 160;
    localparam int unsigned FB_LINES      = 120;
    localparam int unsigned LB_ADDR_W     = 8;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bundle of timing-side, host-write, RAM and line-buffer signals around the arbiter.
interface vga_fb_arbiter_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 8
) ();
    logic              line_start;
    logic [8:0]        line_idx;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              lb_we;
    logic              lb_bank;
    logic [7:0]        lb_addr;
    logic [DATA_W-1:0] lb_data;
    logic              fetch_busy;
    logic              fetch_done;
    logic              underrun;
    logic              underrun_clr;

    // Arbiter side
    modport slave (
        input  line_start, line_idx, wr_valid, wr_addr, wr_data, mem_rdata, underrun_clr,
        output wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
               lb_we, lb_bank, lb_addr, lb_data, fetch_busy, fetch_done, underrun
    );

    // Environment side (timing generator, host, RAM, line buffer)
    modport master (
        output line_start, line_idx, wr_valid, wr_addr, wr_data, mem_rdata, underrun_clr,
        input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
               lb_we, lb_bank, lb_addr, lb_data, fetch_busy, fetch_done, underrun
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: line fetch into ping-pong line buffer with strict
// priority over host writes. Optional macro VGA_ARB_HOST_SLOT_EN gives the
// host every 4th fetch cycle.
module vga_fb_arbiter
    import vga_fb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned DATA_W     = FB_DATA_W,
    parameter int unsigned LINE_WORDS = FB_LINE_WORDS,
    parameter int unsigned LINES      = FB_LINES
) (
    input  logic            clk_25mhz,
    input  logic            reset_n,
    vga_fb_arbiter_if.slave bus
);

    localparam int unsigned LB_W     = LB_ADDR_W;
    localparam int unsigned FB_WORDS = LINES * LINE_WORDS;
    localparam int unsigned LAST_K   = LINE_WORDS - 1;

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              bank_q, bank_d;
    logic [LB_W-1:0]   k_q, k_d;
    logic [LB_W-1:0]   rd_k_q, rd_k_d;
    logic              rd_vld_q, rd_vld_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;
`ifdef VGA_ARB_HOST_SLOT_EN
    logic [1:0]        cyc_q, cyc_d;
`endif

    logic              wr_ready_c, mem_en_c, mem_we_c, do_read_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              idx_ok, wr_in_range, busy;
    logic [ADDR_W-1:0] base_new;

    assign idx_ok      = 32'(bus.line_idx) < LINES;
    assign wr_in_range = 32'(bus.wr_addr) < FB_WORDS;
    assign busy        = (state_q != IDLE);
    assign base_new    = ADDR_W'(32'(bus.line_idx) * LINE_WORDS);

    // Next-state, RAM port steering and abort handling
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        bank_d      = bank_q;
        k_d         = k_q;
        rd_k_d      = rd_k_q;
        rd_vld_d    = 1'b0;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        wr_ready_c  = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = base_q + ADDR_W'(k_q);
        mem_wdata_c = '0;
        do_read_c   = 1'b0;
`ifdef VGA_ARB_HOST_SLOT_EN
        cyc_d       = cyc_q;
`endif

        if (bus.underrun_clr) begin
            underrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.line_start) begin
                    if (idx_ok) begin
                        base_d  = base_new;
                        bank_d  = bus.line_idx[0];
                        k_d     = '0;
                        state_d = FETCH;
`ifdef VGA_ARB_HOST_SLOT_EN
                        cyc_d   = '0;
`endif
                    end
                end else begin
                    wr_ready_c = 1'b1;
                    if (bus.wr_valid) begin
                        mem_en_c    = wr_in_range;
                        mem_we_c    = 1'b1;
                        mem_addr_c  = bus.wr_addr;
                        mem_wdata_c = bus.wr_data;
                    end
                end
            end
            FETCH: begin
                do_read_c = 1'b1;
`ifdef VGA_ARB_HOST_SLOT_EN
                cyc_d = cyc_q + 2'd1;
                if (cyc_q == 2'd3 && bus.wr_valid) begin
                    do_read_c   = 1'b0;
                    wr_ready_c  = 1'b1;
                    mem_en_c    = wr_in_range;
                    mem_we_c    = 1'b1;
                    mem_addr_c  = bus.wr_addr;
                    mem_wdata_c = bus.wr_data;
                end
`endif
                if (do_read_c) begin
                    mem_en_c = 1'b1;
                    rd_vld_d = 1'b1;
                    rd_k_d   = k_q;
                    if (k_q == LB_W'(LAST_K)) begin
                        state_d = DRAIN;
                    end else begin
                        k_d = k_q + LB_W'(1);
                    end
                end
            end
            DRAIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new line request while busy discards the in-flight read and restarts
        if (busy && bus.line_start && idx_ok) begin
            underrun_d = 1'b1;
            rd_vld_d   = 1'b0;
            done_d     = 1'b0;
            base_d     = base_new;
            bank_d     = bus.line_idx[0];
            k_d        = '0;
            state_d    = FETCH;
`ifdef VGA_ARB_HOST_SLOT_EN
            cyc_d      = '0;
`endif
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_25mhz) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            bank_q     <= 1'b0;
            k_q        <= '0;
            rd_k_q     <= '0;
            rd_vld_q   <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef VGA_ARB_HOST_SLOT_EN
            cyc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            bank_q     <= bank_d;
            k_q        <= k_d;
            rd_k_q     <= rd_k_d;
            rd_vld_q   <= rd_vld_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
`ifdef VGA_ARB_HOST_SLOT_EN
            cyc_q      <= cyc_d;
`endif
        end
    end

    // Strobes are gated by reset_n so a reset mid-fetch stops RAM/line-buffer traffic at once
    assign bus.wr_ready   = reset_n & wr_ready_c;
    assign bus.mem_en     = reset_n & mem_en_c;
    assign bus.mem_we     = reset_n & mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.lb_we      = reset_n & rd_vld_q;
    assign bus.lb_bank    = bank_q;
    assign bus.lb_addr    = rd_k_q;
    assign bus.lb_data    = bus.mem_rdata;
    assign bus.fetch_busy = busy;
    assign bus.fetch_done = done_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: idle-state vector table, fetch
// timeline checks, abort/underrun sequence and randomized traffic against a
// framebuffer reference array.
module tb_vga_fb_arbiter;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 8;
    localparam int LW = 160;
    localparam int NL = 120;
    localparam int FBW = LW * NL;

    logic clk_25mhz = 1'b0;
    logic reset_n;

    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vga_fb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .LINES(NL)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #5 clk_25mhz = ~clk_25mhz;

    // RAM model: synchronous write, 1-cycle registered read
    logic [7:0] fb_mem [32768];
    bit         mem_init_done = 1'b0;

    function automatic logic [7:0] init_pat(input int i);
        return 8'((i * 37) ^ (i >> 5));
    endfunction

    always @(posedge clk_25mhz) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 32768; i++) fb_mem[i] <= init_pat(i);
            mem_init_done <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) fb_mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata <= fb_mem[bus.mem_addr];
        end
    end

    // Reference framebuffer contents as the host has written them
    logic [7:0] fb_ref [32768];
    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic idle_inputs();
        bus.line_start   = 1'b0;
        bus.wr_valid     = 1'b0;
        bus.underrun_clr = 1'b0;
    endtask

    // One line fetch from line_start (c=0) to fetch_done (c=LW+2).
    // abort: line_start lands while busy, so cycle 0 outputs belong to the old line.
    task automatic run_fetch(input int idx, input bit abort, input bit clr0,
                             input bit hold_wr, input logic [14:0] wa, input logic [7:0] wd);
        int base = idx * LW;
        int rd_bad = 0, lb_bad = 0, done_bad = 0, busy_bad = 0, rdy_bad = 0;
        int first_rd = -1, first_lb = -1;
        bit exp_busy;
        for (int c = 0; c <= LW + 2; c++) begin
            bus.line_start   = (c == 0);
            bus.line_idx     = 9'(idx);
            bus.underrun_clr = clr0 && (c == 0);
            bus.wr_valid     = hold_wr;
            bus.wr_addr      = wa;
            bus.wr_data      = wd;
            @(negedge clk_25mhz);
            if (c >= 1 && c <= LW) begin
                if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 15'(base + c - 1)) begin
                    rd_bad++;
                    if (first_rd < 0) first_rd = c;
                end
            end else if (c == LW + 2 && hold_wr) begin
                chk("wr_after_fetch_en", 32'(bus.mem_en), 32'(int'(wa) < FBW));
                chk("wr_after_fetch_we", 32'(bus.mem_we), 32'd1);
                chk("wr_after_fetch_addr", 32'(bus.mem_addr), 32'(wa));
                chk("wr_after_fetch_data", 32'(bus.mem_wdata), 32'(wd));
                if (int'(wa) < FBW) fb_ref[wa] = wd;
            end else if (!(abort && c == 0)) begin
                if (bus.mem_en !== 1'b0) begin
                    rd_bad++;
                    if (first_rd < 0) first_rd = c;
                end
            end
            if (c >= 2 && c <= LW + 1) begin
                if (bus.lb_we !== 1'b1 || bus.lb_addr !== 8'(c - 2) || bus.lb_bank !== 1'(idx & 1)
                    || bus.lb_data !== fb_ref[base + c - 2]) begin
                    lb_bad++;
                    if (first_lb < 0) first_lb = c;
                end
            end else if (!(abort && c == 0)) begin
                if (bus.lb_we !== 1'b0) begin
                    lb_bad++;
                    if (first_lb < 0) first_lb = c;
                end
            end
            if (bus.fetch_done !== 1'(c == LW + 2)) done_bad++;
            exp_busy = (c >= 1 && c <= LW + 1) || (abort && c == 0);
            if (bus.fetch_busy !== exp_busy) busy_bad++;
            if (bus.wr_ready !== 1'(c == LW + 2)) rdy_bad++;
            next_cycle();
        end
        idle_inputs();
        chk($sformatf("fetch_rd line=%0d first_bad_cycle=%0d", idx, first_rd), 32'(rd_bad), 32'd0);
        chk($sformatf("fetch_lb line=%0d first_bad_cycle=%0d", idx, first_lb), 32'(lb_bad), 32'd0);
        chk($sformatf("fetch_done_timing line=%0d", idx), 32'(done_bad), 32'd0);
        chk($sformatf("fetch_busy line=%0d", idx), 32'(busy_bad), 32'd0);
        chk($sformatf("wr_ready_in_fetch line=%0d", idx), 32'(rdy_bad), 32'd0);
    endtask

    typedef struct {
        bit          ls;
        logic [8:0]  idx;
        bit          wv;
        logic [14:0] wa;
        logic [7:0]  wd;
        bit          e_rdy;
        bit          e_en;
        bit          e_we;
        bit          e_busy;
        logic [14:0] e_naddr;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1ms;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int wait_n;
        for (int i = 0; i < 32768; i++) fb_ref[i] = init_pat(i);

        //                ls    idx      wv    wa          wd     rdy  en   we   busy naddr
        vecs[0] = '{1'b0, 9'd0,   1'b1, 15'd100,   8'hE0, 1'b1, 1'b1, 1'b1, 1'b0, 15'd0};
        vecs[1] = '{1'b0, 9'd0,   1'b1, 15'd19199, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 15'd0};
        vecs[2] = '{1'b0, 9'd0,   1'b1, 15'd19200, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0};
        vecs[3] = '{1'b0, 9'd0,   1'b1, 15'd32767, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0};
        vecs[4] = '{1'b1, 9'd120, 1'b1, 15'd7,     8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 15'd0};
        vecs[5] = '{1'b1, 9'd511, 1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 15'd0};
        vecs[6] = '{1'b0, 9'd0,   1'b0, 15'd0,     8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 15'd0};
        vecs[7] = '{1'b1, 9'd119, 1'b1, 15'd33,    8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 15'd19040};
        vecs[8] = '{1'b1, 9'd0,   1'b0, 15'd0,     8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15'd0};
        vecs[9] = '{1'b0, 9'd0,   1'b1, 15'd0,     8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 15'd0};

        // Reset held 3 cycles with a pending host write
        reset_n          = 1'b0;
        bus.line_start   = 1'b0;
        bus.line_idx     = 9'd0;
        bus.wr_valid     = 1'b1;
        bus.wr_addr      = 15'd5;
        bus.wr_data      = 8'h00;
        bus.underrun_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_25mhz);
            chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
            chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
            chk("rst_lb_we", 32'(bus.lb_we), 32'd0);
            chk("rst_underrun", 32'(bus.underrun), 32'd0);
            chk("rst_busy", 32'(bus.fetch_busy), 32'd0);
            chk("rst_done", 32'(bus.fetch_done), 32'd0);
        end
        next_cycle();
        reset_n = 1'b1;
        idle_inputs();

        // Idle-state vector table
        for (int v = 0; v < 10; v++) begin
            bus.line_start = vecs[v].ls;
            bus.line_idx   = vecs[v].idx;
            bus.wr_valid   = vecs[v].wv;
            bus.wr_addr    = vecs[v].wa;
            bus.wr_data    = vecs[v].wd;
            @(negedge clk_25mhz);
            chk($sformatf("vec%0d_wr_ready", v), 32'(bus.wr_ready), 32'(vecs[v].e_rdy));
            chk($sformatf("vec%0d_mem_en", v), 32'(bus.mem_en), 32'(vecs[v].e_en));
            if (vecs[v].e_en) begin
                chk($sformatf("vec%0d_mem_we", v), 32'(bus.mem_we), 32'(vecs[v].e_we));
                chk($sformatf("vec%0d_mem_addr", v), 32'(bus.mem_addr), 32'(vecs[v].wa));
                chk($sformatf("vec%0d_mem_wdata", v), 32'(bus.mem_wdata), 32'(vecs[v].wd));
                fb_ref[vecs[v].wa] = vecs[v].wd;
            end
            next_cycle();
            idle_inputs();
            @(negedge clk_25mhz);
            chk($sformatf("vec%0d_busy_next", v), 32'(bus.fetch_busy), 32'(vecs[v].e_busy));
            if (vecs[v].e_busy) begin
                chk($sformatf("vec%0d_first_rd_addr", v), 32'(bus.mem_addr), 32'(vecs[v].e_naddr));
                wait_n = 0;
                while (bus.fetch_done !== 1'b1 && wait_n < 400) begin
                    next_cycle();
                    @(negedge clk_25mhz);
                    wait_n++;
                end
                chk($sformatf("vec%0d_wait_done", v), 32'(wait_n < 400), 32'd1);
            end else begin
                chk($sformatf("vec%0d_no_mem_en_next", v), 32'(bus.mem_en), 32'd0);
            end
            next_cycle();
        end

        // Plain fetch of line 2
        run_fetch(2, 1'b0, 1'b0, 1'b0, 15'd0, 8'h00);

`ifndef VGA_ARB_HOST_SLOT_EN
        // Host write held through a fetch of line 5
        run_fetch(5, 1'b0, 1'b0, 1'b1, 15'd100, 8'hE0);
`endif

        // Abort at k=50 of line 3 by a request for line 7, with a same-cycle clear
        begin
            int bad = 0, lbc = 0, lbmax = -1;
            @(negedge clk_25mhz);
            chk("underrun_before_abort", 32'(bus.underrun), 32'd0);
            next_cycle();
            for (int c = 0; c <= 50; c++) begin
                bus.line_start = (c == 0);
                bus.line_idx   = 9'd3;
                @(negedge clk_25mhz);
                if (c >= 1 && (bus.mem_en !== 1'b1 || bus.mem_addr !== 15'(480 + c - 1))) bad++;
                if (bus.lb_we === 1'b1) begin
                    lbc++;
                    lbmax = int'(bus.lb_addr);
                end
                if (bus.fetch_done !== 1'b0) bad++;
                next_cycle();
            end
            chk("abort_pre_reads", 32'(bad), 32'd0);
            chk("abort_pre_lb_count", 32'(lbc), 32'd49);
            chk("abort_pre_lb_last", 32'(lbmax), 32'd48);
            run_fetch(7, 1'b1, 1'b1, 1'b0, 15'd0, 8'h00);
            @(negedge clk_25mhz);
            chk("underrun_set_wins", 32'(bus.underrun), 32'd1);
            next_cycle();
            bus.underrun_clr = 1'b1;
            next_cycle();
            bus.underrun_clr = 1'b0;
            @(negedge clk_25mhz);
            chk("underrun_cleared", 32'(bus.underrun), 32'd0);
            next_cycle();
        end

        // Randomized host writes in IDLE followed by line requests
        for (int it = 0; it < 20; it++) begin
            int nw = $urandom_range(1, 5);
            int idx;
            bit hold;
            logic [14:0] wa;
            logic [7:0]  wd;
            for (int w = 0; w < nw; w++) begin
                bus.wr_valid = 1'($urandom_range(0, 1));
                wa = 15'($urandom_range(0, 20000));
                wd = 8'($urandom);
                bus.wr_addr = wa;
                bus.wr_data = wd;
                @(negedge clk_25mhz);
                chk("rnd_wr_ready", 32'(bus.wr_ready), 32'd1);
                chk("rnd_mem_en", 32'(bus.mem_en), 32'(bus.wr_valid && int'(wa) < FBW));
                if (bus.wr_valid && int'(wa) < FBW) begin
                    chk("rnd_mem_we", 32'(bus.mem_we), 32'd1);
                    chk("rnd_mem_addr", 32'(bus.mem_addr), 32'(wa));
                    chk("rnd_mem_wdata", 32'(bus.mem_wdata), 32'(wd));
                    fb_ref[wa] = wd;
                end
                next_cycle();
            end
            idle_inputs();
            if ($urandom_range(0, 9) == 0) begin
                int bad = 0;
                bus.line_start = 1'b1;
                bus.line_idx   = 9'($urandom_range(120, 511));
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk_25mhz);
                    if (bus.fetch_busy !== 1'b0 || bus.mem_en !== 1'b0) bad++;
                    next_cycle();
                    bus.line_start = 1'b0;
                end
                chk("rnd_bad_idx_ignored", 32'(bad), 32'd0);
            end else begin
                idx = $urandom_range(0, NL - 1);
`ifndef VGA_ARB_HOST_SLOT_EN
                hold = 1'($urandom_range(0, 1));
`else
                hold = 1'b0;
`endif
                wa = 15'($urandom_range(0, 20000));
                wd = 8'($urandom);
                run_fetch(idx, 1'b0, 1'b0, hold, wa, wd);
            end
        end

`ifdef VGA_ARB_HOST_SLOT_EN
        // Continuous host traffic during a line-0 fetch: every 4th fetch cycle is a host slot
        begin
            int k = 0, n = 0, wcnt = 0, lbn = 0, rd_bad = 0, wr_bad = 0, lb_bad = 0;
            bit pend = 1'b0;
            bus.line_start = 1'b1;
            bus.line_idx   = 9'd0;
            @(negedge clk_25mhz);
            chk("slot_start_mem_en", 32'(bus.mem_en), 32'd0);
            next_cycle();
            bus.line_start = 1'b0;
            while (k < LW && n < 400) begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = 15'(5000 + wcnt);
                bus.wr_data  = 8'(wcnt ^ 8'h3C);
                @(negedge clk_25mhz);
                if (pend) begin
                    if (bus.lb_we !== 1'b1 || bus.lb_addr !== 8'(lbn) || bus.lb_data !== fb_ref[lbn]) lb_bad++;
                    lbn++;
                end else if (bus.lb_we !== 1'b0) lb_bad++;
                if (n % 4 == 3) begin
                    if (bus.wr_ready !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1
                        || bus.mem_addr !== 15'(5000 + wcnt) || bus.mem_wdata !== 8'(wcnt ^ 8'h3C)) wr_bad++;
                    fb_ref[5000 + wcnt] = 8'(wcnt ^ 8'h3C);
                    wcnt++;
                    pend = 1'b0;
                end else begin
                    if (bus.wr_ready !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0
                        || bus.mem_addr !== 15'(k)) rd_bad++;
                    k++;
                    pend = 1'b1;
                end
                n++;
                next_cycle();
            end
            bus.wr_valid = 1'b0;
            @(negedge clk_25mhz);
            if (bus.lb_we !== 1'b1 || bus.lb_addr !== 8'(lbn) || bus.lb_data !== fb_ref[lbn]) lb_bad++;
            lbn++;
            chk("slot_drain_mem_en", 32'(bus.mem_en), 32'd0);
            next_cycle();
            @(negedge clk_25mhz);
            chk("slot_fetch_done", 32'(bus.fetch_done), 32'd1);
            chk("slot_reads", 32'(rd_bad), 32'd0);
            chk("slot_writes", 32'(wr_bad), 32'd0);
            chk("slot_lb_order", 32'(lb_bad), 32'd0);
            chk("slot_lb_count", 32'(lbn), 32'(LW));
            chk("slot_write_count", 32'(wcnt), 32'd53);
            next_cycle();
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
